// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - two-port round-robin front end sharing one 16-bit shifter, 5-bit amounts
//
// shifter      : combinational 16-bit shifter, amount 0-15
//   d, amt, typ   operand, amount, type (00 LSL, 01 LSR, 10 ASR, 11 ROR)
//   q, c          result and last bit shifted out (0 when amt == 0)
//
// shift_arbiter: arbitrates port A / port B onto the shifter, registers the result
//   clk, rst_n                 clock, asynchronous active-low reset
//   a_valid/a_ready/a_data/a_amt/a_type   port A request handshake and operands
//   b_valid/b_ready/b_data/b_amt/b_type   port B request handshake and operands
//   r_valid/r_ready/r_data/r_c/r_src      registered result, carry and source (0 = A, 1 = B)

module shifter (
  input  logic [15:0] d,
  input  logic [3:0]  amt,
  input  logic [1:0]  typ,
  output logic [15:0] q,
  output logic        c
);
  logic [31:0]        t;
  logic signed [31:0] ts;

  always_comb begin
    t  = '0;
    ts = {d, 16'h0000};
    q  = '0;
    c  = 1'b0;
    case (typ)
      2'b00: begin
        // Operand in the low half; the first bit above it is the last one pushed out.
        t = {16'h0000, d} << amt;
        q = t[15:0];
        c = t[16];
      end
      2'b01: begin
        // Operand in the high half; the first bit below it is the last one pushed out.
        t = {d, 16'h0000} >> amt;
        q = t[31:16];
        c = t[15];
      end
      2'b10: begin
        t = $unsigned(ts >>> amt);
        q = t[31:16];
        c = t[15];
      end
      default: begin
        t = {d, d} >> amt;
        q = t[15:0];
        c = (amt != 4'd0) & t[15];
      end
    endcase
  end
endmodule

module shift_arbiter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         a_valid,
  output logic         a_ready,
  input  logic [W-1:0] a_data,
  input  logic [4:0]   a_amt,
  input  logic [1:0]   a_type,
  input  logic         b_valid,
  output logic         b_ready,
  input  logic [W-1:0] b_data,
  input  logic [4:0]   b_amt,
  input  logic [1:0]   b_type,
  output logic         r_valid,
  input  logic         r_ready,
  output logic [W-1:0] r_data,
  output logic         r_c,
  output logic         r_src
);
  typedef enum logic {IDLE = 1'b0, PASS2 = 1'b1} state_t;

  state_t       state, state_nxt;
  logic         last;
  logic [W-1:0] work;
  logic [3:0]   rem;
  logic         rem16;
  logic [1:0]   typ_q;
  logic         src_q;

  logic         out_free, can_accept, grant_a, grant_b, grant;
  logic [W-1:0] g_data;
  logic [4:0]   g_amt;
  logic [1:0]   g_typ;
  logic         g_long;
  logic [4:0]   rem_full;

  logic [15:0]  sh_d, sh_q;
  logic [3:0]   sh_amt;
  logic [1:0]   sh_typ;
  logic         sh_c;
  logic         load_r, load_work;

  // Grant logic: rst_n gating keeps both readies low while reset is held.
  assign out_free   = !r_valid || r_ready;
  assign can_accept = rst_n && (state == IDLE) && out_free;
  assign grant_a    = can_accept && a_valid && (!b_valid || last);
  assign grant_b    = can_accept && b_valid && (!a_valid || !last);
  assign grant      = grant_a || grant_b;
  assign a_ready    = grant_a;
  assign b_ready    = grant_b;

  assign g_data   = grant_b ? b_data : a_data;
  assign g_amt    = grant_b ? b_amt  : a_amt;
  assign g_typ    = grant_b ? b_type : a_type;
  assign g_long   = g_amt[4];
  // Amounts 16..31 leave 1..16 after the first 15-bit pass; bit 4 flags the 16 case.
  assign rem_full = g_amt - 5'd15;

  shifter u_shifter (
    .d   (sh_d),
    .amt (sh_amt),
    .typ (sh_typ),
    .q   (sh_q),
    .c   (sh_c)
  );

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant && g_long) state_nxt = PASS2;
      default: if (out_free && !rem16) state_nxt = IDLE;
    endcase
  end

  // FSM: shifter operand mux and load enables
  always_comb begin
    sh_d      = g_data;
    sh_amt    = g_long ? 4'd15 : g_amt[3:0];
    sh_typ    = g_typ;
    load_r    = 1'b0;
    load_work = 1'b0;
    if (state == PASS2) begin
      sh_d   = work;
      // A remainder of 16 is split into 15 now and 1 on the following cycle.
      sh_amt = rem16 ? 4'd15 : rem;
      sh_typ = typ_q;
      if (out_free) begin
        load_work = rem16;
        load_r    = !rem16;
      end
    end else if (grant) begin
      load_work = g_long;
      load_r    = !g_long;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last  <= 1'b1;
      work  <= '0;
      rem   <= '0;
      rem16 <= 1'b0;
      typ_q <= '0;
      src_q <= 1'b0;
    end else begin
      if (grant) last <= grant_b;
      if (load_work) begin
        work <= sh_q;
        if (state == IDLE) begin
          rem   <= rem_full[3:0];
          rem16 <= rem_full[4];
          typ_q <= g_typ;
          src_q <= grant_b;
        end else begin
          rem   <= 4'd1;
          rem16 <= 1'b0;
        end
      end
    end
  end

  // Result register: reloads on the same edge that drains the previous result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_c     <= 1'b0;
      r_src   <= 1'b0;
    end else if (load_r) begin
      r_valid <= 1'b1;
      r_data  <= sh_q;
      r_c     <= sh_c;
      r_src   <= (state == PASS2) ? src_q : grant_b;
    end else if (r_ready) begin
      r_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_shift_arbiter.sv
// tb/tb_shift_arbiter.sv - scoreboard bench for shift_arbiter
module tb_shift_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, b_valid, r_ready;
  logic        a_ready, b_ready, r_valid, r_c, r_src;
  logic [15:0] a_data, b_data, r_data;
  logic [4:0]  a_amt, b_amt;
  logic [1:0]  a_type, b_type;

  typedef struct packed {
    logic [15:0] d;
    logic        c;
    logic        src;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  shift_arbiter #(.W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_amt(a_amt), .a_type(a_type),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data), .b_amt(b_amt), .b_type(b_type),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_c(r_c), .r_src(r_src)
  );

  // Reference: whole 5-bit shift in one go; carry is the last bit to leave the operand.
  function automatic logic [16:0] model(input logic [15:0] d, input logic [4:0] n, input logic [1:0] ty);
    logic [47:0]        t;
    logic signed [47:0] ts;
    logic [31:0]        rr;
    logic [15:0]        q;
    logic               c;
    t  = '0;
    ts = {d, 32'h0};
    rr = {d, d} >> n[3:0];
    case (ty)
      2'b00: begin t = {32'h0, d} << n; q = t[15:0];  c = t[16]; end
      2'b01: begin t = {d, 32'h0} >> n; q = t[47:32]; c = t[31]; end
      2'b10: begin t = $unsigned(ts >>> n); q = t[47:32]; c = t[31]; end
      default: begin q = rr[15:0]; c = (n != 5'd0) & q[15]; end
    endcase
    return {c, q};
  endfunction

  function automatic exp_t mk(input logic [15:0] d, input logic [4:0] n, input logic [1:0] ty, input logic src);
    logic [16:0] m;
    m = model(d, n, ty);
    return '{d: m[15:0], c: m[16], src: src};
  endfunction

  task automatic idle_inputs();
    a_valid = 0; b_valid = 0;
    a_data = '0; b_data = '0; a_amt = '0; b_amt = '0; a_type = '0; b_type = '0;
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst_n = 0; idle_inputs(); sb.delete();
    @(negedge clk); rst_n = 1;
  endtask

  // Drive one request and hold it until granted (bounded); expected result goes to the scoreboard.
  task automatic issue(input bit port, input logic [15:0] d, input logic [4:0] n, input logic [1:0] ty, output bit ok);
    ok = 0;
    @(posedge clk); #1;
    if (port) begin b_valid = 1; b_data = d; b_amt = n; b_type = ty; end
    else      begin a_valid = 1; a_data = d; a_amt = n; a_type = ty; end
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (port ? b_ready : a_ready) ok = 1;
      @(posedge clk); #1;
    end
    if (port) b_valid = 0; else a_valid = 0;
    if (ok) sb.push_back(mk(d, n, ty, port));
  endtask

  // Cycles from the accept edge until r_valid is seen (0 = never within budget).
  task automatic wait_result(output int lat);
    lat = 0;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      @(negedge clk);
      if (r_valid) lat = i;
      else begin @(posedge clk); #1; end
    end
  endtask

  task automatic pop_exp(output exp_t e);
    if (sb.size() == 0) e = '{d: 16'hxxxx, c: 1'bx, src: 1'bx};
    else e = sb.pop_front();
  endtask

  task automatic test_reset();
    rst_n = 0; r_ready = 1; idle_inputs();
    a_valid = 1; b_valid = 1;
    repeat (2) @(negedge clk);
    vectors++; if (r_valid !== 1'b0) begin miscompares++; $display("FAIL reset_r_valid got %b exp 0", r_valid); end
    vectors++; if (r_data !== 16'h0) begin miscompares++; $display("FAIL reset_r_data got %h exp 0000", r_data); end
    vectors++; if ({r_c, r_src} !== 2'b00) begin miscompares++; $display("FAIL reset_r_c_src got %b exp 00", {r_c, r_src}); end
    vectors++; if ({a_ready, b_ready} !== 2'b00) begin miscompares++; $display("FAIL reset_ready got %b exp 00", {a_ready, b_ready}); end
    idle_inputs();
    rst_n = 1;
  endtask

  task automatic test_short_types();
    logic [15:0] lit [4];
    logic        lit_c [4];
    exp_t        e;
    bit          ok;
    int          lat;
    lit = '{16'h8640, 16'h1E19, 16'hFE19, 16'h1E19};
    lit_c = '{1'b1, 1'b0, 1'b0, 1'b0};
    r_ready = 1;
    for (int ty = 0; ty < 4; ty++) begin
      issue(0, 16'hF0C8, 5'd3, 2'(ty), ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL short_accept type %0d got no grant exp grant", ty); end
      wait_result(lat);
      vectors++; if (lat != 1) begin miscompares++; $display("FAIL short_latency type %0d got %0d exp 1", ty, lat); end
      pop_exp(e);
      vectors++; if (r_data !== lit[ty]) begin miscompares++; $display("FAIL short_data type %0d got %h exp %h", ty, r_data, lit[ty]); end
      vectors++; if (r_c !== lit_c[ty]) begin miscompares++; $display("FAIL short_carry type %0d got %b exp %b", ty, r_c, lit_c[ty]); end
      vectors++; if ({r_data, r_c, r_src} !== {e.d, e.c, e.src}) begin miscompares++; $display("FAIL short_sb type %0d got %h/%b/%b exp %h/%b/%b", ty, r_data, r_c, r_src, e.d, e.c, e.src); end
    end
  endtask

  task automatic test_contention();
    exp_t e;
    bit   exp_b;
    pulse_reset();
    r_ready = 1;
    @(posedge clk); #1;
    a_valid = 1; a_data = 16'h1234; a_amt = 5'd1; a_type = 2'b00;
    b_valid = 1; b_data = 16'h8421; b_amt = 5'd2; b_type = 2'b10;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      exp_b = (i % 2) == 1;
      vectors++; if ({a_ready, b_ready} !== {!exp_b, exp_b}) begin miscompares++; $display("FAIL contention_grant cycle %0d got a=%b b=%b exp a=%b b=%b", i, a_ready, b_ready, !exp_b, exp_b); end
      if (i > 0) begin
        pop_exp(e);
        vectors++; if ({r_valid, r_data, r_c, r_src} !== {1'b1, e.d, e.c, e.src}) begin miscompares++; $display("FAIL contention_result cycle %0d got v=%b %h/%b/%b exp %h/%b/%b", i, r_valid, r_data, r_c, r_src, e.d, e.c, e.src); end
      end
      sb.push_back(exp_b ? mk(b_data, b_amt, b_type, 1'b1) : mk(a_data, a_amt, a_type, 1'b0));
      @(posedge clk); #1;
    end
    a_valid = 0; b_valid = 0;
    @(negedge clk);
    pop_exp(e);
    vectors++; if ({r_valid, r_data, r_c, r_src} !== {1'b1, e.d, e.c, e.src}) begin miscompares++; $display("FAIL contention_last got v=%b %h/%b/%b exp %h/%b/%b", r_valid, r_data, r_c, r_src, e.d, e.c, e.src); end
  endtask

  task automatic test_long_shift();
    logic [1:0]  tys [3];
    logic [15:0] lit [3];
    exp_t        e;
    tys = '{2'b10, 2'b11, 2'b00};
    lit = '{16'hFFFF, 16'h1800, 16'h0000};
    r_ready = 1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      b_valid = 1; b_data = 16'h8001; b_amt = 5'd20; b_type = tys[k];
      @(negedge clk);
      vectors++; if (b_ready !== 1'b1) begin miscompares++; $display("FAIL long_b_ready k %0d got %b exp 1", k, b_ready); end
      sb.push_back(mk(16'h8001, 5'd20, tys[k], 1'b1));
      @(posedge clk); #1;
      b_valid = 0;
      a_valid = 1; a_data = 16'h0F0F; a_amt = 5'd4; a_type = 2'b01;
      @(negedge clk);
      vectors++; if ({a_ready, r_valid} !== 2'b00) begin miscompares++; $display("FAIL long_pass2_stall k %0d got a_ready=%b r_valid=%b exp 0 0", k, a_ready, r_valid); end
      @(posedge clk); #1;
      @(negedge clk);
      pop_exp(e);
      vectors++; if (r_data !== lit[k]) begin miscompares++; $display("FAIL long_data k %0d got %h exp %h", k, r_data, lit[k]); end
      vectors++; if ({r_valid, r_c, r_src} !== {1'b1, e.c, 1'b1}) begin miscompares++; $display("FAIL long_sb k %0d got v=%b c=%b src=%b exp 1 %b 1", k, r_valid, r_c, r_src, e.c); end
      vectors++; if (a_ready !== 1'b1) begin miscompares++; $display("FAIL long_a_after k %0d got %b exp 1", k, a_ready); end
      sb.push_back(mk(16'h0F0F, 5'd4, 2'b01, 1'b0));
      @(posedge clk); #1;
      a_valid = 0;
      @(negedge clk);
      pop_exp(e);
      vectors++; if ({r_valid, r_data, r_c, r_src} !== {1'b1, e.d, e.c, e.src}) begin miscompares++; $display("FAIL long_follow k %0d got v=%b %h/%b/%b exp %h/%b/%b", k, r_valid, r_data, r_c, r_src, e.d, e.c, e.src); end
    end
  endtask

  task automatic test_boundary();
    logic [4:0]  amts [3];
    logic [15:0] lit [3];
    int          lats [3];
    exp_t        e;
    bit          ok;
    int          lat;
    amts = '{5'd0, 5'd16, 5'd31};
    lit  = '{16'h0001, 16'h0001, 16'h0002};
    lats = '{1, 2, 3};
    r_ready = 1;
    for (int k = 0; k < 3; k++) begin
      issue(0, 16'h0001, amts[k], 2'b11, ok);
      wait_result(lat);
      vectors++; if (lat != lats[k]) begin miscompares++; $display("FAIL boundary_latency amt %0d got %0d exp %0d", amts[k], lat, lats[k]); end
      pop_exp(e);
      vectors++; if (r_data !== lit[k]) begin miscompares++; $display("FAIL boundary_data amt %0d got %h exp %h", amts[k], r_data, lit[k]); end
      vectors++; if ({r_c, r_src} !== {e.c, 1'b0}) begin miscompares++; $display("FAIL boundary_c_src amt %0d got %b%b exp %b0", amts[k], r_c, r_src, e.c); end
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    bit   ok;
    r_ready = 1;
    @(posedge clk); #1;
    r_ready = 0;
    issue(0, 16'hA5A5, 5'd4, 2'b11, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL bp_accept got no grant exp grant"); end
    b_valid = 1; b_data = 16'h00FF; b_amt = 5'd8; b_type = 2'b01;
    e = (sb.size() > 0) ? sb[0] : '{d: 16'hxxxx, c: 1'bx, src: 1'bx};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++; if ({r_valid, r_data, r_c, r_src} !== {1'b1, e.d, e.c, e.src}) begin miscompares++; $display("FAIL bp_hold cycle %0d got v=%b %h/%b/%b exp %h/%b/%b", i, r_valid, r_data, r_c, r_src, e.d, e.c, e.src); end
      vectors++; if ({a_ready, b_ready} !== 2'b00) begin miscompares++; $display("FAIL bp_ready cycle %0d got %b exp 00", i, {a_ready, b_ready}); end
      @(posedge clk); #1;
    end
    r_ready = 1;
    @(negedge clk);
    vectors++; if (b_ready !== 1'b1) begin miscompares++; $display("FAIL bp_same_cycle_grant got %b exp 1", b_ready); end
    pop_exp(e);
    vectors++; if ({r_valid, r_data, r_src} !== {1'b1, e.d, e.src}) begin miscompares++; $display("FAIL bp_drain got v=%b %h/%b exp %h/%b", r_valid, r_data, r_src, e.d, e.src); end
    sb.push_back(mk(16'h00FF, 5'd8, 2'b01, 1'b1));
    @(posedge clk); #1;
    b_valid = 0;
    @(negedge clk);
    pop_exp(e);
    vectors++; if ({r_valid, r_data, r_c, r_src} !== {1'b1, e.d, e.c, e.src}) begin miscompares++; $display("FAIL bp_next got v=%b %h/%b/%b exp %h/%b/%b", r_valid, r_data, r_c, r_src, e.d, e.c, e.src); end
  endtask

  task automatic test_random();
    exp_t        e;
    bit          ok;
    int          lat, exp_lat;
    logic        port;
    logic [15:0] d;
    logic [4:0]  n;
    logic [1:0]  ty;
    r_ready = 1;
    for (int k = 0; k < 12; k++) begin
      port = 1'($urandom_range(0, 1));
      d    = 16'($urandom);
      n    = 5'($urandom_range(0, 31));
      ty   = 2'($urandom_range(0, 3));
      exp_lat = (n < 16) ? 1 : (n < 31) ? 2 : 3;
      issue(port, d, n, ty, ok);
      wait_result(lat);
      vectors++; if (lat != exp_lat) begin miscompares++; $display("FAIL rand_latency %0d amt %0d got %0d exp %0d", k, n, lat, exp_lat); end
      pop_exp(e);
      vectors++; if ({r_data, r_c, r_src} !== {e.d, e.c, e.src}) begin miscompares++; $display("FAIL rand_result %0d d %h amt %0d ty %0d got %h/%b/%b exp %h/%b/%b", k, d, n, ty, r_data, r_c, r_src, e.d, e.c, e.src); end
    end
  endtask

  task automatic test_reset_mid_op();
    exp_t e;
    bit   ok;
    r_ready = 1;
    issue(0, 16'h1234, 5'd20, 2'b00, ok);
    a_valid = 1; a_data = 16'h00F0; a_amt = 5'd2; a_type = 2'b01;
    b_valid = 1; b_data = 16'h0F00; b_amt = 5'd3; b_type = 2'b00;
    rst_n = 0;
    #1;
    vectors++; if ({r_valid, r_data, r_c, r_src} !== 19'h0) begin miscompares++; $display("FAIL midreset_outputs got v=%b %h/%b/%b exp all 0", r_valid, r_data, r_c, r_src); end
    vectors++; if ({a_ready, b_ready} !== 2'b00) begin miscompares++; $display("FAIL midreset_ready got %b exp 00", {a_ready, b_ready}); end
    sb.delete();
    @(negedge clk);
    rst_n = 1;
    #1;
    vectors++; if ({a_ready, b_ready} !== 2'b10) begin miscompares++; $display("FAIL midreset_first_grant got a=%b b=%b exp a=1 b=0", a_ready, b_ready); end
    sb.push_back(mk(16'h00F0, 5'd2, 2'b01, 1'b0));
    @(posedge clk); #1;
    a_valid = 0; b_valid = 0;
    @(negedge clk);
    pop_exp(e);
    vectors++; if ({r_valid, r_data, r_c, r_src} !== {1'b1, e.d, e.c, e.src}) begin miscompares++; $display("FAIL midreset_result got v=%b %h/%b/%b exp %h/%b/%b", r_valid, r_data, r_c, r_src, e.d, e.c, e.src); end
  endtask

  initial begin
    test_reset();
    test_short_types();
    test_contention();
    test_long_shift();
    test_boundary();
    test_backpressure();
    test_random();
    test_reset_mid_op();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got no finish exp finish");
    $fatal(1);
  end
endmodule
